// File: rtl/lfsr_frame_seq.sv
// lfsr_frame_seq: drives an external XNOR lfsr_wrapper and frames its output
// into lines and frames on a valid/ready stream, with optional inter-line gaps
// and optional per-line seed reload.
module lfsr_frame_seq #(
  parameter int DW  = 8,
  parameter int HW  = 16,
  parameter int VW  = 16,
  parameter int GAP = 4
) (
  input  logic          i_sysclk,
  input  logic          i_arstn,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [DW-1:0] i_seed,
  input  logic [HW-1:0] i_hsize,
  input  logic [VW-1:0] i_vsize,
  input  logic          i_seed_per_line,
  output logic          o_lfsr_load,
  output logic          o_lfsr_en,
  output logic [DW-1:0] o_lfsr_seed,
  input  logic [DW-1:0] i_lfsr,
  output logic          o_tvalid,
  output logic [DW-1:0] o_tdata,
  output logic          o_tlast,
  output logic          o_tuser,
  input  logic          i_tready,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACTIVE,
    S_GAP,
    S_DONE
  } state_t;

  // Gap counter only needs to reach GAP-1; keep at least one bit so GAP=0/1 elaborate.
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t        state, state_next;
  logic [HW-1:0] hcnt, hcnt_next;
  logic [VW-1:0] vcnt, vcnt_next;
  logic [GW-1:0] gcnt, gcnt_next;
  logic [HW-1:0] hsize_cfg, hsize_cfg_next;
  logic [VW-1:0] vsize_cfg, vsize_cfg_next;
  logic [DW-1:0] seed_cfg, seed_cfg_next;
  logic          per_line_cfg, per_line_cfg_next;

  logic accept;
  logic h_last;
  logic v_last;

  // Latched sizes are never zero while framing, so the -1 cannot wrap.
  assign h_last = (hcnt == hsize_cfg - HW'(1));
  assign v_last = (vcnt == vsize_cfg - VW'(1));
  assign accept = o_tvalid & i_tready;

  // State, counter and latched-configuration registers
  always_ff @(posedge i_sysclk or negedge i_arstn) begin
    if (!i_arstn) begin
      state        <= S_IDLE;
      hcnt         <= '0;
      vcnt         <= '0;
      gcnt         <= '0;
      hsize_cfg    <= '0;
      vsize_cfg    <= '0;
      seed_cfg     <= '0;
      per_line_cfg <= 1'b0;
    end else begin
      state        <= state_next;
      hcnt         <= hcnt_next;
      vcnt         <= vcnt_next;
      gcnt         <= gcnt_next;
      hsize_cfg    <= hsize_cfg_next;
      vsize_cfg    <= vsize_cfg_next;
      seed_cfg     <= seed_cfg_next;
      per_line_cfg <= per_line_cfg_next;
    end
  end

  // Next state and counter updates; abort overrides every state
  always_comb begin
    state_next        = state;
    hcnt_next         = hcnt;
    vcnt_next         = vcnt;
    gcnt_next         = gcnt;
    hsize_cfg_next    = hsize_cfg;
    vsize_cfg_next    = vsize_cfg;
    seed_cfg_next     = seed_cfg;
    per_line_cfg_next = per_line_cfg;

    if (i_abort) begin
      state_next = S_IDLE;
      hcnt_next  = '0;
      vcnt_next  = '0;
      gcnt_next  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && (i_hsize != '0) && (i_vsize != '0)) begin
            hsize_cfg_next    = i_hsize;
            vsize_cfg_next    = i_vsize;
            // All ones locks up an XNOR LFSR, so it is swapped for all zeros.
            seed_cfg_next     = (&i_seed) ? '0 : i_seed;
            per_line_cfg_next = i_seed_per_line;
            state_next        = S_LOAD;
          end
        end
        S_LOAD: begin
          state_next = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (accept) begin
            if (h_last) begin
              hcnt_next = '0;
              if (v_last) begin
                vcnt_next  = '0;
                state_next = S_DONE;
              end else begin
                vcnt_next = vcnt + VW'(1);
                if (GAP > 0)           state_next = S_GAP;
                else if (per_line_cfg) state_next = S_LOAD;
                else                   state_next = S_ACTIVE;
              end
            end else begin
              hcnt_next = hcnt + HW'(1);
            end
          end
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) begin
            gcnt_next  = '0;
            state_next = per_line_cfg ? S_LOAD : S_ACTIVE;
          end else begin
            gcnt_next = gcnt + GW'(1);
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Moore-style stream/control outputs; LFSR enable follows the handshake
  always_comb begin
    o_tvalid    = (state == S_ACTIVE);
    o_tdata     = o_tvalid ? i_lfsr : '0;
    o_tlast     = o_tvalid && h_last;
    o_tuser     = o_tvalid && (hcnt == '0) && (vcnt == '0);
    o_lfsr_en   = o_tvalid & i_tready;
    o_lfsr_load = (state == S_LOAD);
    o_lfsr_seed = seed_cfg;
    o_busy      = (state != S_IDLE);
    o_done      = (state == S_DONE);
  end

endmodule

// File: tb/tb_lfsr_frame_seq.sv
// tb_lfsr_frame_seq: directed and randomized frames against a queue-based
// reference of the expected beat list, with an XNOR LFSR model attached.
module tb_lfsr_frame_seq;

  localparam int DW  = 8;
  localparam int HW  = 16;
  localparam int VW  = 16;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          arstn;
  logic          i_start, i_abort, i_seed_per_line, i_tready;
  logic [DW-1:0] i_seed;
  logic [HW-1:0] i_hsize;
  logic [VW-1:0] i_vsize;
  logic          o_lfsr_load, o_lfsr_en, o_tvalid, o_tlast, o_tuser, o_busy, o_done;
  logic [DW-1:0] o_lfsr_seed, o_tdata;
  logic [DW-1:0] lfsr = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int base_got, base_done, c0;
  logic [9:0] got[$];
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  lfsr_frame_seq #(.DW(DW), .HW(HW), .VW(VW), .GAP(GAP)) dut (
    .i_sysclk(clk), .i_arstn(arstn), .i_start(i_start), .i_abort(i_abort),
    .i_seed(i_seed), .i_hsize(i_hsize), .i_vsize(i_vsize),
    .i_seed_per_line(i_seed_per_line), .o_lfsr_load(o_lfsr_load),
    .o_lfsr_en(o_lfsr_en), .o_lfsr_seed(o_lfsr_seed), .i_lfsr(lfsr),
    .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tuser(o_tuser),
    .i_tready(i_tready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // XNOR LFSR, taps 8,6,5,4: shift left, feed back the inverted parity of the taps.
  function automatic logic [7:0] step(input logic [7:0] x);
    return {x[6:0], ~(x[7] ^ x[5] ^ x[4] ^ x[3])};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Stand-in for the external lfsr_wrapper
  always @(posedge clk) begin
    if (o_lfsr_load)    lfsr <= o_lfsr_seed;
    else if (o_lfsr_en) lfsr <= step(lfsr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect accepted beats, done pulses, check hold-under-stall
  always @(negedge clk) begin
    if (arstn) begin
      if (o_tvalid && i_tready) got.push_back({o_tuser, o_tlast, o_tdata});
      if (o_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (prev_stall && o_tvalid) check("hold_data", o_tdata, prev_data);
      if (!i_tready) check("en_while_stalled", o_lfsr_en, 0);
    end
    prev_stall <= arstn && o_tvalid && !i_tready;
    prev_data  <= o_tdata;
  end

  task automatic kick(input logic [7:0] seed, input int h, input int v, input bit pl);
    @(posedge clk); #1;
    i_seed = seed; i_hsize = HW'(h); i_vsize = VW'(v); i_seed_per_line = pl;
    i_start = 1'b1; c0 = cyc;
    base_got = got.size(); base_done = done_cnt;
    @(posedge clk); #1;
    i_start = 1'b0;
    // Scramble the config inputs: the frame must use the latched values.
    i_seed = 8'($urandom); i_hsize = HW'($urandom); i_vsize = VW'($urandom);
    i_seed_per_line = 1'($urandom);
    check("load_after_start", o_lfsr_load, 1);
  endtask

  // mode 0: ready=1, 1: random ready, 2: ready low 3 cycles on beat 2
  task automatic run_frame(input logic [7:0] seed, input int h, input int v,
                           input bit pl, input int mode);
    logic [9:0] expq[$];
    logic [7:0] s, cur;
    int stalls = 0;
    int hold = 0;
    int len;
    s = (seed == 8'hFF) ? 8'h00 : seed;
    cur = s;
    for (int vi = 0; vi < v; vi++) begin
      if (pl || vi == 0) cur = s;
      for (int hi = 0; hi < h; hi++) begin
        expq.push_back({(vi == 0 && hi == 0), (hi == h - 1), cur});
        cur = step(cur);
      end
    end
    kick(seed, h, v, pl);
    for (int n = 0; n < 3000; n++) begin
      if (done_cnt != base_done) break;
      if (mode == 1) i_tready = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && (got.size() - base_got) == 2 && o_tvalid && hold < 3) begin
        i_tready = 1'b0; hold++;
      end else i_tready = 1'b1;
      if (o_tvalid && !i_tready) stalls++;
      @(posedge clk); #1;
    end
    i_tready = 1'b1;
    check("done_pulses", done_cnt - base_done, 1);
    check("busy_after_done", o_busy, 0);
    check("done_one_cycle", o_done, 0);
    len = 1 + h * v + (v - 1) * (GAP + int'(pl)) + 1 + stalls;
    check("frame_len", done_cyc - c0, len);
    check("beat_count", got.size() - base_got, expq.size());
    for (int i = 0; i < expq.size() && base_got + i < got.size(); i++)
      check($sformatf("beat%0d", i), got[base_got + i], expq[i]);
    $display("frame seed=%02h H=%0d V=%0d pl=%0d mode=%0d beats=%0d stalls=%0d",
             seed, h, v, pl, mode, got.size() - base_got, stalls);
  endtask

  task automatic zero_start(input int h, input int v);
    @(posedge clk); #1;
    i_hsize = HW'(h); i_vsize = VW'(v); i_seed = 8'h01; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("zero_size_busy", o_busy, 0);
    repeat (3) @(posedge clk);
    #1 check("zero_size_load", {o_busy, o_lfsr_load}, 0);
    $display("zero-size start H=%0d V=%0d ignored", h, v);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while ((got.size() - base_got) < n && k < 500) begin
      @(posedge clk); #1; k++;
    end
    check("wait_beats_timeout", (k < 500), 1);
  endtask

  task automatic do_abort(input string tag);
    int d0;
    d0 = done_cnt;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    check({tag, "_tvalid"}, o_tvalid, 0);
    check({tag, "_busy"}, o_busy, 0);
    repeat (8) @(posedge clk);
    #1 check({tag, "_no_done"}, done_cnt - d0, 0);
    $display("abort %s done", tag);
  endtask

  initial begin
    int k;
    arstn = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_tready = 1'b1;
    i_seed = '0; i_hsize = '0; i_vsize = '0; i_seed_per_line = 1'b0;
    #3;
    check("reset_outputs", {o_lfsr_load, o_lfsr_en, o_lfsr_seed, o_tvalid, o_tdata,
                            o_tlast, o_tuser, o_busy, o_done}, 0);
    #9 arstn = 1'b1;

    run_frame(8'h01, 5, 1, 1'b0, 0);   // free-running 01 03 07 0F 1E
    run_frame(8'h01, 5, 1, 1'b0, 2);   // back-pressure on beat 2
    run_frame(8'h01, 2, 3, 1'b1, 0);   // reload per line
    run_frame(8'h01, 2, 3, 1'b0, 0);   // continue across lines
    zero_start(0, 3);
    zero_start(4, 0);
    run_frame(8'h01, 1, 1, 1'b0, 0);   // single beat, tuser+tlast
    run_frame(8'hFF, 3, 2, 1'b1, 0);   // lock-up seed substituted

    // Abort during the second line
    kick(8'h01, 4, 3, 1'b0);
    wait_beats(5);
    do_abort("abort_line2");

    // Abort during an inter-line gap
    kick(8'h01, 2, 2, 1'b1);
    wait_beats(2);
    k = 0;
    while (!(o_busy && !o_tvalid && !o_lfsr_load && !o_done) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("reach_gap", (k < 50), 1);
    do_abort("abort_gap");

    // Start and abort together in IDLE
    @(posedge clk); #1;
    i_hsize = 16'd3; i_vsize = 16'd1; i_start = 1'b1; i_abort = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    check("start_abort_idle", o_busy, 0);

    run_frame(8'h01, 5, 1, 1'b0, 0);   // recovery after abort

    // Asynchronous reset mid-frame, away from a clock edge
    kick(8'h01, 8, 2, 1'b0);
    wait_beats(3);
    @(negedge clk); #2;
    arstn = 1'b0;
    #1;
    check("async_reset_outputs", {o_lfsr_load, o_lfsr_en, o_lfsr_seed, o_tvalid, o_tdata,
                                  o_tlast, o_tuser, o_busy, o_done}, 0);
    $display("async reset asserted mid-frame");
    @(negedge clk); #2 arstn = 1'b1;
    run_frame(8'h01, 3, 2, 1'b0, 1);

    // Randomized frames
    for (int r = 0; r < 8; r++) begin
      logic [7:0] sd;
      sd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      run_frame(sd, $urandom_range(1, 6), $urandom_range(1, 3),
                1'($urandom), $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
